// File: rtl/armleocpu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, cache flush and the fetch/decode handshake.
// The master modport is the fetch side. The slave modport is the memory/decode environment.
interface armleocpu_fetch_if;
    localparam int ARMLEOCPU_D2F_CMD_WIDTH = 2;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [1:0]  mem_resp_error;

    logic        cache_flush;
    logic        cache_flush_done;

    logic [31:0] f2d_instr;
    logic        f2d_instr_valid;
    logic [31:0] f2d_pc;
    logic [1:0]  f2d_fetch_error;

    logic                               d2f_ready;
    logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd;
    logic [31:0]                        d2f_branchtarget;

    modport master (
        output mem_req_valid, mem_req_addr, cache_flush,
        output f2d_instr, f2d_instr_valid, f2d_pc, f2d_fetch_error,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
        input  cache_flush_done, d2f_ready, d2f_cmd, d2f_branchtarget
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, cache_flush,
        input  f2d_instr, f2d_instr_valid, f2d_pc, f2d_fetch_error,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
        output cache_flush_done, d2f_ready, d2f_cmd, d2f_branchtarget
    );
endinterface

// File: rtl/armleocpu_fetch.sv
// ArmleoCPU instruction fetch: one outstanding memory read, a registered f2d output,
// and branch/flush redirects from decode that kill any fetch still in flight.
module armleocpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    armleocpu_fetch_if.master    bus
);
    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_STALL = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_kill;
    logic        r_flush_pending;
    logic [31:0] r_f2d_instr;
    logic [31:0] r_f2d_pc;
    logic [1:0]  r_f2d_error;
    logic        r_f2d_valid;

    logic        w_cmd_branch;
    logic        w_cmd_flush;
    logic        w_cmd;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_accept;
    logic [1:0]  w_resp_error;

    assign w_cmd_branch = (bus.d2f_cmd == 2'b01);
    assign w_cmd_flush  = (bus.d2f_cmd == 2'b10);
    assign w_cmd        = w_cmd_branch || w_cmd_flush;
    assign w_target     = {bus.d2f_branchtarget[31:2], 2'b00};
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_accept     = bus.mem_req_valid && bus.mem_req_ready;
    // Code 11 is folded into access fault so decode only ever sees 00/01/10.
    assign w_resp_error = (bus.mem_resp_error == 2'b11) ? 2'b01 : bus.mem_resp_error;

    assign bus.mem_req_valid   = (r_state == S_REQ) && !rst;
    assign bus.mem_req_addr    = r_req_addr;
    assign bus.cache_flush     = (r_state == S_FLUSH) && !rst;
    assign bus.f2d_instr       = r_f2d_instr;
    assign bus.f2d_instr_valid = r_f2d_valid;
    assign bus.f2d_pc          = r_f2d_pc;
    assign bus.f2d_fetch_error = r_f2d_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_VECTOR;
            r_req_addr      <= RESET_VECTOR;
            r_kill          <= 1'b0;
            r_flush_pending <= 1'b0;
            r_f2d_instr     <= NOP_INSTR;
            r_f2d_pc        <= RESET_VECTOR;
            r_f2d_error     <= 2'b00;
            r_f2d_valid     <= 1'b0;
        end else begin
            if (w_cmd) begin
                r_pc <= w_target;
            end
            case (r_state)
                S_REQ: begin
                    // A request already on the bus must stay stable, so it is only marked dead.
                    if (w_cmd) begin
                        r_kill <= 1'b1;
                        if (w_cmd_flush) begin
                            r_flush_pending <= 1'b1;
                        end
                    end
                    if (w_accept) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (w_cmd) begin
                            r_kill     <= 1'b0;
                            r_req_addr <= w_target;
                            if (w_cmd_flush || r_flush_pending) begin
                                r_flush_pending <= 1'b0;
                                r_state         <= S_FLUSH;
                            end else begin
                                r_state <= S_REQ;
                            end
                        end else if (r_kill) begin
                            r_kill     <= 1'b0;
                            r_req_addr <= r_pc;
                            if (r_flush_pending) begin
                                r_flush_pending <= 1'b0;
                                r_state         <= S_FLUSH;
                            end else begin
                                r_state <= S_REQ;
                            end
                        end else begin
                            r_f2d_instr <= (w_resp_error == 2'b00) ? bus.mem_resp_data : NOP_INSTR;
                            r_f2d_pc    <= r_req_addr;
                            r_f2d_error <= w_resp_error;
                            r_f2d_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_cmd) begin
                        r_kill <= 1'b1;
                        if (w_cmd_flush) begin
                            r_flush_pending <= 1'b1;
                        end
                    end
                end
                S_HOLD, S_STALL: begin
                    if (w_cmd) begin
                        r_f2d_valid <= 1'b0;
                        if (w_cmd_branch) begin
                            r_req_addr <= w_target;
                            r_state    <= S_REQ;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end else if ((r_state == S_HOLD) && bus.d2f_ready) begin
                        r_f2d_valid <= 1'b0;
                        if (r_f2d_error == 2'b00) begin
                            r_pc       <= w_pc_plus4;
                            r_req_addr <= w_pc_plus4;
                            r_state    <= S_REQ;
                        end else begin
                            r_state <= S_STALL;
                        end
                    end
                end
                S_FLUSH: begin
                    // A redirect arriving alongside done keeps the flush up one more round.
                    if (!w_cmd && bus.cache_flush_done) begin
                        r_req_addr <= r_pc;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: doc/armleocpu_fetch.md
# armleocpu_fetch

Instruction fetch stage of the ArmleoCPU pipeline, directly upstream of decode. It holds the program counter and issues one instruction-memory read at a time. Each returned word, with its PC and fetch error, is presented to decode over the f2d valid/ready handshake. It accepts redirect and flush commands from decode (d2f_cmd, d2f_branchtarget) and discards any in-flight fetch they invalidate.

## Interface
- RESET_VECTOR, 32'h0000_2000, first PC fetched after reset
- NOP_INSTR, 32'h0000_0013, value driven on f2d_instr when the word is invalid or has an error
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- mem_req_valid  out  1  read request
- mem_req_ready  in  1  request accepted when valid&ready
- mem_req_addr  out  32  word address; stable while valid&!ready
- mem_resp_valid  in  1  response strobe; one response per accepted request
- mem_resp_data  in  32  instruction word
- mem_resp_error  in  2  00 none, 01 access fault, 10 page fault, 11 treated as access fault
- cache_flush  out  1  instruction-cache flush request; held until done
- cache_flush_done  in  1  flush complete
- f2d_instr  out  32  instruction
- f2d_instr_valid  out  1  instruction presented
- f2d_pc  out  32  PC of f2d_instr
- f2d_fetch_error  out  2  error code, same encoding as mem_resp_error
- d2f_ready  in  1  decode consumes the instruction when valid&ready
- d2f_cmd  in  ARMLEOCPU_D2F_CMD_WIDTH (2)  00 NONE, 01 BRANCH, 10 FLUSH, 11 treated as NONE
- d2f_branchtarget  in  32  new PC for BRANCH/FLUSH; bits [1:0] are forced to 0

## Operation
- State registers: pc, req_addr, state, kill, flush_pending.
- States:
  - REQ: mem_req_valid=1, mem_req_addr=req_addr. On accept -> WAIT.
  - WAIT: wait for the response.
  - HOLD: instruction presented to decode.
  - STALL: after an error, wait for a command.
  - FLUSH: cache_flush=1 until cache_flush_done, then -> REQ.
- Response in WAIT:
  - kill=0, no command this cycle: latch f2d_instr=data, f2d_pc=req_addr, f2d_fetch_error=error; f2d_instr_valid=1; -> HOLD.
  - Error responses drive f2d_instr=NOP_INSTR.
  - kill=1: discard the response; clear kill; go to FLUSH if flush_pending (clear it), else REQ with req_addr=pc.
- HOLD with d2f_ready=1 and no command:
  - No error: pc=pc+4 (mod 2^32), req_addr=pc+4, valid drops next cycle, -> REQ.
  - Error: valid drops, -> STALL. No further fetch until a command arrives.
- Command (BRANCH/FLUSH), sampled every cycle, takes precedence over the handshake:
  - pc=target.
  - In REQ or WAIT: kill=1 (a request pending in REQ still completes and is killed). FLUSH also sets flush_pending. A response arriving in the same cycle as the command is discarded (-> REQ, or FLUSH on a FLUSH command, with req_addr=target).
  - In HOLD or STALL: f2d_instr_valid=0 next cycle; BRANCH -> REQ with req_addr=target; FLUSH -> FLUSH.
  - In FLUSH: pc updates; the state stays FLUSH.
  - A second command while kill=1: pc updates to the latest target. flush_pending is only ever set, never cleared, by commands.
- Leaving FLUSH: req_addr=pc.
- A response with kill=0 arriving outside WAIT is ignored.

## Timing
- Reset values:
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_VECTOR, cache_flush=0, f2d_instr_valid=0, f2d_instr=NOP_INSTR, f2d_pc=RESET_VECTOR, f2d_fetch_error=0.
  - Internal: state=REQ, pc=RESET_VECTOR, kill=0, flush_pending=0.
- First mem_req_valid=1 in the first cycle after rst deasserts.
- Reset mid-operation drops all state within one cycle; the memory is reset by the same rst.
- mem_req_valid and cache_flush are decoded from state; f2d_* are registers.
- Response in cycle N -> f2d_instr_valid=1 in N+1.
- Decode handshake in cycle M -> next mem_req_valid in M+1. With a zero-wait memory, peak throughput is 1 instruction per 3 cycles.
- Command in HOLD at cycle C -> request for the target in C+1.

## Test plan
- Reset, memory always ready, 1-cycle response, d2f_ready=1 -> addresses 0x2000, 0x2004, 0x2008 with f2d_pc matching and error 00.
- Hold d2f_ready=0 for 5 cycles -> f2d_instr/f2d_pc stable, no new request; release -> next request at pc+4 the following cycle.
- BRANCH to 0x8000 while in WAIT for 0x2004 -> the 0x2004 response is never presented; next request is 0x8000. Also check BRANCH in the same cycle as mem_resp_valid.
- Response error 10 at 0x2008 -> f2d_instr=0x00000013, error=10; after the handshake no requests for 10 cycles; BRANCH to 0x100 -> fetch resumes at 0x100.
- FLUSH to 0x4000 in WAIT -> response discarded, cache_flush high until cache_flush_done (done held low 3 cycles), then request 0x4000.
- PC 0xFFFFFFFC consumed -> next request at 0x00000000; BRANCH target 0x8003 -> request 0x8000.
